// File: rtl/if_icache_if.sv
// Fetch-stage bus: PC-side lookup, memory fetch handshake and issued instruction.
// Handshake: inst_fe requests inst_fpc; memory answers with a one-cycle inst_ok pulse carrying inst/inst_pc.
interface if_icache_if;
    logic [31:0] pc;
    logic        flush;
    logic        inst_ok;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_fe;
    logic [31:0] inst_fpc;
    logic        if_stall;

    modport master (
        output pc, flush, inst_ok, inst, inst_pc,
        input  pc_o, inst_o, inst_fe, inst_fpc, if_stall
    );

    modport slave (
        input  pc, flush, inst_ok, inst, inst_pc,
        output pc_o, inst_o, inst_fe, inst_fpc, if_stall
    );
endinterface

// File: rtl/if_icache.sv
// Instruction fetch stage with direct-mapped multi-word-line I-cache and line refill FSM.
// Define ICACHE_EN to build the cache; otherwise every fetch goes through the forwarding path.
module if_icache #(
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    if_icache_if.slave  bus,
    output logic        state_o
);

`ifdef ICACHE_EN
    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << OFFSET_BITS;
    localparam int OFF_W = (OFFSET_BITS > 0) ? OFFSET_BITS : 1;
    localparam int TAG_W = 30 - OFFSET_BITS - INDEX_BITS;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [OFF_W-1:0]        cnt_q, cnt_d;
    logic [31:0]             fpc_q, fpc_d;
    logic [INDEX_BITS-1:0]   rf_idx_q, rf_idx_d;
    logic [TAG_W-1:0]        rf_tag_q, rf_tag_d;
    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [31:0]             data_q [LINES][WORDS];

    logic [29:0]             pc_word;
    logic [INDEX_BITS-1:0]   idx;
    logic [TAG_W-1:0]        tag;
    logic [OFF_W-1:0]        off;
    logic [31:0]             line_base;
    logic                    hit;
    logic                    fwd;
    logic                    start;
    logic                    wr_en;
    logic                    last_word;
    logic                    fill_done;
    logic [31:0]             pc_out;
    logic [31:0]             inst_out;
    logic                    stall_out;
    logic                    unused_bits;

    assign pc_word   = bus.pc[31:2];
    assign idx       = INDEX_BITS'(pc_word >> OFFSET_BITS);
    assign tag       = TAG_W'(pc_word >> (OFFSET_BITS + INDEX_BITS));
    assign off       = (OFFSET_BITS == 0) ? '0 : OFF_W'(pc_word);
    assign line_base = {(pc_word >> OFFSET_BITS) << OFFSET_BITS, 2'b00};
    assign last_word = (cnt_q == OFF_W'(WORDS - 1));

    // The line under refill has its valid bit cleared, so it can never hit early.
    assign hit   = valid_q[idx] && (tag_q[idx] == tag);
    assign fwd   = !hit && bus.inst_ok && (bus.inst_pc[31:2] == pc_word);
    assign start = (state_q == IDLE) && !hit && !bus.flush;
    assign wr_en = (state_q == REFILL) && bus.inst_ok && !bus.flush;
    assign fill_done = wr_en && last_word;

    always_comb begin
        pc_out    = '0;
        inst_out  = '0;
        stall_out = 1'b0;
        if (!rst) begin
            if (hit) begin
                pc_out   = bus.pc;
                inst_out = data_q[idx][off];
            end else if (fwd) begin
                pc_out   = bus.pc;
                inst_out = bus.inst;
            end else begin
                stall_out = 1'b1;
            end
        end
    end

    assign bus.pc_o     = pc_out;
    assign bus.inst_o   = inst_out;
    assign bus.if_stall = stall_out;
    assign bus.inst_fe  = (state_q == REFILL) && !bus.inst_ok;
    assign bus.inst_fpc = fpc_q;
    assign state_o      = (state_q == REFILL);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fpc_d    = fpc_q;
        rf_idx_d = rf_idx_q;
        rf_tag_d = rf_tag_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = REFILL;
                    rf_idx_d = idx;
                    rf_tag_d = tag;
                    cnt_d    = '0;
                    fpc_d    = line_base;
                end
            end
            REFILL: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.inst_ok) begin
                    cnt_d = cnt_q + 1'b1;
                    fpc_d = fpc_q + 32'd4;
                    if (last_word) begin
                        fpc_d   = bus.pc + 32'd4;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            fpc_q    <= '0;
            rf_idx_q <= '0;
            rf_tag_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fpc_q    <= fpc_d;
            rf_idx_q <= rf_idx_d;
            rf_tag_q <= rf_tag_d;
        end
    end

    // Flush beats both refill start and a last-word completion in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (bus.flush) begin
            valid_q <= '0;
        end else if (start) begin
            valid_q[idx] <= 1'b0;
        end else if (fill_done) begin
            valid_q[rf_idx_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[rf_idx_q][cnt_q] <= bus.inst;
        end
        if (fill_done) begin
            tag_q[rf_idx_q] <= rf_tag_q;
        end
    end

    assign unused_bits = ^{bus.pc[1:0], bus.inst_pc[1:0]};

`else
    localparam int unused_geom = INDEX_BITS + OFFSET_BITS;

    logic [31:0] fpc_q;
    logic        fwd;
    logic        unused_bits;

    assign fwd = bus.inst_ok && (bus.inst_pc[31:2] == bus.pc[31:2]);

    // Request the next sequential word once the current one has been acknowledged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q <= '0;
        end else if (bus.inst_ok) begin
            fpc_q <= bus.pc + 32'd4;
        end else begin
            fpc_q <= bus.pc;
        end
    end

    assign bus.pc_o     = (!rst && fwd) ? bus.pc : 32'd0;
    assign bus.inst_o   = (!rst && fwd) ? bus.inst : 32'd0;
    assign bus.if_stall = !rst && !fwd;
    assign bus.inst_fe  = !bus.inst_ok && !rst;
    assign bus.inst_fpc = fpc_q;
    assign state_o      = 1'b0;

    assign unused_bits = ^{bus.flush, bus.pc[1:0], bus.inst_pc[1:0]};
`endif

endmodule

// File: tb/tb_if_icache.sv
// Bench for if_icache: directed scenarios plus random fetch traffic against a line-level reference model.
module tb_if_icache;
  localparam int LINES = 64;
  localparam int WORDS = 4;

  logic clk = 1'b0;
  logic rst;
  logic dbg_state;

  if_icache_if bus();

  if_icache #(.INDEX_BITS(6), .OFFSET_BITS(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: line numbers are address >> 4, index = line % 64
  bit          m_valid [LINES];
  int unsigned m_lno   [LINES];
  logic [31:0] m_data  [LINES][WORDS];
  bit          m_refill;
  logic [31:0] m_base;
  int          m_cnt;
  logic [31:0] m_fpc;

  // memory responder
  bit          drv_busy;
  int          drv_cnt;
  logic [31:0] drv_addr;
  int          drv_lat_fixed;

  // last cycle observations
  logic [31:0] obs_inst, obs_pc, obs_fpc, obs_req_addr;
  logic        obs_stall, obs_fe, obs_ok, obs_state, obs_req;

  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: return 32'h11;
      32'h104: return 32'h22;
      32'h108: return 32'h33;
      32'h10c: return 32'h44;
      default: return {a[15:0] ^ 16'hc3a5, a[31:16] ^ a[15:0]};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_refill = 1'b0;
    m_cnt    = 0;
    m_fpc    = 32'd0;
    drv_busy = 1'b0;
    drv_cnt  = 0;
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    int unsigned lno = a >> 4;
    return m_valid[lno % LINES] && (m_lno[lno % LINES] == lno);
  endfunction

  task automatic model_update();
`ifdef ICACHE_EN
    int unsigned ridx;
    bit hit = model_hit(bus.pc);
    if (bus.flush) begin
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      m_refill = 1'b0;
    end else if (!m_refill) begin
      if (!hit) begin
        m_refill = 1'b1;
        m_base   = bus.pc & ~32'hf;
        m_cnt    = 0;
        m_valid[(bus.pc >> 4) % LINES] = 1'b0;
        m_fpc    = m_base;
      end
    end else if (bus.inst_ok) begin
      ridx = (m_base >> 4) % LINES;
      m_data[ridx][m_cnt] = bus.inst;
      m_cnt++;
      m_fpc = m_fpc + 32'd4;
      if (m_cnt == WORDS) begin
        m_lno[ridx]   = m_base >> 4;
        m_valid[ridx] = 1'b1;
        m_refill      = 1'b0;
        m_fpc         = bus.pc + 32'd4;
      end
    end
`else
    m_fpc = bus.inst_ok ? bus.pc + 32'd4 : bus.pc;
`endif
  endtask

  // one clock: drive memory response, check outputs at negedge, advance model at posedge
  task automatic cycle();
    logic [31:0] e_pc, e_inst;
    logic        e_stall, e_fe, e_state, hit, fwd;
    int unsigned idx, w;
    bus.inst_ok = 1'b0;
    bus.inst    = $urandom;
    bus.inst_pc = $urandom & 32'hffff_fffc;
    if (drv_busy) begin
      if (drv_cnt == 0) begin
        bus.inst_ok = 1'b1;
        bus.inst    = mem_word(drv_addr);
        bus.inst_pc = drv_addr;
        drv_busy    = 1'b0;
      end else begin
        drv_cnt--;
      end
    end
    @(negedge clk);
    idx = (bus.pc >> 4) % LINES;
    w   = (bus.pc >> 2) % WORDS;
`ifdef ICACHE_EN
    hit     = model_hit(bus.pc);
    e_fe    = m_refill && !bus.inst_ok;
    e_state = m_refill;
`else
    hit     = 1'b0;
    e_fe    = !bus.inst_ok;
    e_state = 1'b0;
`endif
    fwd = !hit && bus.inst_ok && (bus.inst_pc[31:2] == bus.pc[31:2]);
    e_pc = 32'd0; e_inst = 32'd0; e_stall = 1'b1;
    if (hit) begin
      e_pc = bus.pc; e_inst = m_data[idx][w]; e_stall = 1'b0;
    end else if (fwd) begin
      e_pc = bus.pc; e_inst = bus.inst; e_stall = 1'b0;
    end
    check("pc_o", bus.pc_o, e_pc);
    check("inst_o", bus.inst_o, e_inst);
    check("if_stall", {31'd0, bus.if_stall}, {31'd0, e_stall});
    check("inst_fe", {31'd0, bus.inst_fe}, {31'd0, e_fe});
    check("inst_fpc", bus.inst_fpc, m_fpc);
    check("state", {31'd0, dbg_state}, {31'd0, e_state});
    obs_inst = bus.inst_o; obs_pc = bus.pc_o; obs_fpc = bus.inst_fpc;
    obs_stall = bus.if_stall; obs_fe = bus.inst_fe; obs_ok = bus.inst_ok;
    obs_state = dbg_state; obs_req = 1'b0;
    if (!drv_busy && bus.inst_fe) begin
      drv_busy     = 1'b1;
      drv_addr     = bus.inst_fpc;
      drv_cnt      = (drv_lat_fixed > 0 ? drv_lat_fixed : int'($urandom_range(1, 3))) - 1;
      obs_req      = 1'b1;
      obs_req_addr = bus.inst_fpc;
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_pc_o"}, bus.pc_o, 32'd0);
    check({tag, "_inst_o"}, bus.inst_o, 32'd0);
    check({tag, "_stall"}, {31'd0, bus.if_stall}, 32'd0);
    check({tag, "_fe"}, {31'd0, bus.inst_fe}, 32'd0);
    check({tag, "_fpc"}, bus.inst_fpc, 32'd0);
    check({tag, "_state"}, {31'd0, dbg_state}, 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 80; i++) begin
      if (!m_refill) break;
      cycle();
    end
    check(tag, {31'd0, m_refill}, 32'd0);
  endtask

  task automatic fill(input logic [31:0] a, input string tag);
    bus.pc = a;
    cycle();
    wait_idle(tag);
  endtask

  initial begin
    int acks, fwd_ack;
    logic [31:0] fwd_inst;
    bit first_seen;
    int stall_run;
    logic [31:0] pool [6];
    pool = '{32'h100, 32'h1100, 32'h400, 32'h200, 32'h2100, 32'h8400};

    rst = 1'b1;
    bus.pc = 32'h100; bus.flush = 1'b0;
    bus.inst_ok = 1'b0; bus.inst = 32'd0; bus.inst_pc = 32'd0;
    drv_lat_fixed = 2;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("rst");
    rst = 1'b0;

`ifdef ICACHE_EN
    // line fill with critical word forwarding
    exp_q = {32'h100, 32'h104, 32'h108, 32'h10c};
    first_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (i == 0) check("miss_stall", {31'd0, obs_stall}, 32'd1);
      if (obs_req) begin
        if (exp_q.size() > 0) check("fpc_seq", obs_req_addr, exp_q.pop_front());
        else check("fpc_extra", obs_req_addr, 32'hffff_ffff);
      end
      if (obs_ok && !first_seen) begin
        first_seen = 1'b1;
        check("crit_fwd_inst", obs_inst, 32'h11);
        check("crit_fwd_stall", {31'd0, obs_stall}, 32'd0);
      end
      if (!m_refill) break;
    end
    check("fpc_seq_left", exp_q.size(), 32'd0);
    check("d1_done", {31'd0, m_refill}, 32'd0);
    bus.pc = 32'h108;
    cycle();
    check("hit_inst", obs_inst, 32'h33);
    check("hit_stall", {31'd0, obs_stall}, 32'd0);
    check("hit_pc", obs_pc, 32'h108);

    // critical word in the middle of a line
    bus.pc = 32'h208;
    acks = 0; fwd_ack = 0; fwd_inst = 32'd0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (obs_ok) begin
        acks++;
        if (!obs_stall) begin fwd_ack = acks; fwd_inst = obs_inst; end
      end
      if (!m_refill) break;
    end
    check("mid_fwd_ack", fwd_ack, 32'd3);
    check("mid_fwd_inst", fwd_inst, mem_word(32'h208));

    // conflict eviction, then hit-under-refill
    fill(32'h400, "fill_400");
    fill(32'h1100, "fill_1100");
    bus.pc = 32'h100;
    cycle();
    check("conflict_miss", {31'd0, obs_stall}, 32'd1);
    bus.pc = 32'h400;
    cycle();
    check("hur_stall", {31'd0, obs_stall}, 32'd0);
    check("hur_inst", obs_inst, mem_word(32'h400));
    check("hur_state", {31'd0, obs_state}, 32'd1);
    wait_idle("hur_done");
    bus.pc = 32'h100;
    cycle();
    check("refilled_hit", obs_inst, 32'h11);

    // flush on the second ack of a refill
    bus.pc = 32'h1100;
    cycle();
    acks = 0;
    for (int i = 0; i < 60; i++) begin
      if (drv_busy && drv_cnt == 0 && acks == 1) bus.flush = 1'b1;
      cycle();
      bus.flush = 1'b0;
      if (obs_ok) acks++;
      if (acks == 2) break;
    end
    check("flush_acks", acks, 32'd2);
    bus.pc = 32'h100;
    cycle();
    check("flush_state", {31'd0, obs_state}, 32'd0);
    check("flush_fe", {31'd0, obs_fe}, 32'd0);
    check("flush_miss_100", {31'd0, obs_stall}, 32'd1);
    bus.pc = 32'h400;
    cycle();
    check("flush_miss_400", {31'd0, obs_stall}, 32'd1);
    wait_idle("flush_done");

    // asynchronous reset in the middle of a refill
    bus.pc = 32'h2100;
    cycle();
    cycle();
    #2 rst = 1'b1;
    #1 check_reset_outs("mid_rst");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.pc = 32'h100;
    cycle();
    check("post_rst_miss", {31'd0, obs_stall}, 32'd1);
    wait_idle("post_rst_done");

    // random traffic
    drv_lat_fixed = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 4) == 0)
        bus.pc = pool[$urandom_range(0, 5)] + 32'($urandom_range(0, 3)) * 32'd4;
      bus.flush = ($urandom_range(0, 49) == 0);
      cycle();
    end
    bus.flush = 1'b0;
`else
    // pass-through fetch: pc 0 with 3-cycle ack
    drv_lat_fixed = 3;
    bus.pc = 32'h0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("nc_wait_stall", {31'd0, obs_stall}, 32'd1);
      if (i == 0) check("nc_req_addr", obs_req_addr, 32'h0);
    end
    cycle();
    check("nc_ack_stall", {31'd0, obs_stall}, 32'd0);
    check("nc_ack_inst", obs_inst, mem_word(32'h0));
    check("nc_ack_pc", obs_pc, 32'h0);
    cycle();
    check("nc_refetch_stall", {31'd0, obs_stall}, 32'd1);
    check("nc_next_fpc", obs_fpc, 32'h4);

    // random sequential fetch with jumps, flush pulses ignored
    drv_lat_fixed = 0;
    stall_run = 0;
    for (int i = 0; i < 2500; i++) begin
      if (!obs_stall) begin
        stall_run = 0;
        if ($urandom_range(0, 7) == 0) bus.pc = ($urandom & 32'h0000_fffc);
        else bus.pc = bus.pc + 32'd4;
      end else begin
        stall_run++;
        if (stall_run > 8) begin
          bus.pc = obs_fpc;
          stall_run = 0;
        end
      end
      bus.flush = ($urandom_range(0, 19) == 0);
      cycle();
    end
    bus.flush = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/if_icache.md
# if_icache

Parametrised instruction-fetch stage with a direct-mapped, multi-word-line I-cache and a line-refill state machine. It sits between the PC register and IF/ID. Hits are served in the same cycle. A miss triggers a sequential refill of the whole line from the memory controller over the fetch request/ack handshake. The word the stalled PC is waiting for is forwarded as soon as it arrives. A flush input invalidates the whole cache for `fence.i`.

## Interface
- `INDEX_BITS`, default 6: number of lines is 2^INDEX_BITS.
- `OFFSET_BITS`, default 2: words per line is 2^OFFSET_BITS. Legal range 0..4; 0 gives one word per line.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `pc` in 32: fetch address, word aligned; bits [1:0] are ignored.
- `flush` in 1: invalidate all lines; single-cycle pulse.
- `inst_ok` in 1: one-cycle pulse; memory returns `inst` for `inst_pc`.
- `inst` in 32: returned instruction word.
- `inst_pc` in 32: address of the returned word.
- `pc_o` out 32: PC of the issued instruction.
- `inst_o` out 32: issued instruction.
- `inst_fe` out 1: fetch request to the memory controller.
- `inst_fpc` out 32: fetch request address, registered.
- `if_stall` out 1: IF cannot supply `pc` this cycle.

## Operation
- Address split:
  - tag = `pc[31:2+OFFSET_BITS+INDEX_BITS]`
  - index = `pc[2+OFFSET_BITS+INDEX_BITS-1 : 2+OFFSET_BITS]`
  - word offset = `pc[2+OFFSET_BITS-1:2]`
- Per line the block keeps one valid bit, one tag and 2^OFFSET_BITS data words.
- Hit means valid[index] is set and the stored tag equals the pc tag. On a hit: `inst_o` = word at (index, offset), `pc_o` = `pc`, `if_stall` = 0.
- The hit path is evaluated in every state. Hits to lines other than the one being refilled proceed during REFILL.
- Forwarding: if there is no hit, but `inst_ok` is high and `inst_pc` equals `pc` (bits [31:2]), then `inst_o` = `inst`, `pc_o` = `pc`, `if_stall` = 0.
- Otherwise: `if_stall` = 1, `inst_o` = 0, `pc_o` = 0.
- FSM states are IDLE and REFILL.
- IDLE to REFILL: on a miss while `flush` is low.
  - Latch line base = `pc` with bits [2+OFFSET_BITS-1:0] cleared.
  - Clear valid[index].
  - Set word counter to 0 and `inst_fpc` to the line base.
- In REFILL: `inst_fe` = ~`inst_ok`, giving a one-cycle gap after each ack. In IDLE, `inst_fe` = 0.
- On `inst_ok` in REFILL:
  - Write `inst` into word (counter) of the latched index.
  - Increment the counter and advance `inst_fpc` by 4.
  - On the last word: write the tag, set valid, set `inst_fpc` to `pc`+4, return to IDLE.
- A `pc` change during REFILL does not abort the refill. The new `pc` is looked up normally, and a new miss is handled after return to IDLE.
- `flush`:
  - Clears all valid bits on the next edge.
  - In REFILL, it aborts the refill and returns to IDLE; the partial line stays invalid.
  - If `flush` coincides with the last-word `inst_ok`, flush wins and the line is invalid.
  - A miss in the same cycle as `flush` does not start a refill; it retries next cycle.
- An `inst_ok` in IDLE is ignored apart from forwarding.

## Timing
- Reset state: FSM in IDLE, counter 0, `inst_fpc` 0, all valid bits 0, data and tags unspecified.
- While `rst` is high: `pc_o` 0, `inst_o` 0, `if_stall` 0, `inst_fe` 0.
- Hit latency: 0 cycles, combinational from `pc`.
- Miss:
  - Cycle 0: `if_stall` = 1, miss detected.
  - Cycle 1: REFILL, `inst_fe` = 1, `inst_fpc` = line base.
  - Each word costs memory latency plus one gap cycle.
  - The critical word is forwarded in its `inst_ok` cycle.
  - The full line is hittable from the cycle after the last ack.
- Reset asserted mid-refill returns to the reset state immediately, asynchronously.

## Configuration
- `ICACHE_EN`:
  - Defined: behaviour as above.
  - Undefined: no storage and no REFILL state; `INDEX_BITS` and `OFFSET_BITS` are unused.
    - `inst_fe` = ~`inst_ok` & ~`rst`.
    - `inst_fpc` is registered `pc`, or `pc`+4 on `inst_ok`.
    - Output comes only through the forwarding path, so each instruction stalls until its ack.
    - `flush` is ignored.

## Test plan
All scenarios use INDEX_BITS=6 and OFFSET_BITS=2.
- Reset, then hold `pc`=0x100 and return 0x11,0x22,0x33,0x44 for 0x100..0x10C with 2-cycle latency:
  - `inst_fpc` steps 0x100, 0x104, 0x108, 0x10C.
  - `inst_o`=0x11 is forwarded in the first ack cycle.
  - `pc`=0x108 afterwards hits with 0x33, `if_stall` 0.
- Miss at `pc`=0x208 (line 0x200): `inst_o`=word from `inst_pc` 0x208 is forwarded on the third ack, not the first.
- Conflict: fill line 0x100, then fetch 0x1100 (same index, different tag):
  - Refill occurs.
  - 0x100 misses afterwards.
- Hit-under-refill: during refill of 0x100, switch `pc` to a previously filled line 0x400 → same-cycle hit, `if_stall` 0, refill still completes.
- `flush` pulsed during the second ack of a refill:
  - FSM goes to IDLE, `inst_fe` 0.
  - Next fetch of 0x100 misses.
  - Previously valid 0x400 also misses.
- With `ICACHE_EN` undefined, `pc`=0x0 with a 3-cycle ack: `if_stall` 1 for 3 cycles, then 1 cycle with `inst_o` = `inst`; a refetch of 0x0 stalls again.
